// File: rtl/dac8563_multi_ctrl_pkg.sv
// Shared encodings and frame builders for the DAC8563 controller.
// Frames are {2'b00, cmd[2:0], addr[2:0], data[15:0]}, shifted MSB first.
package dac8563_multi_ctrl_pkg;

  localparam logic [2:0] CMD_WR_IN      = 3'b000;
  localparam logic [2:0] CMD_WR_UPD_ALL = 3'b010;
  localparam logic [2:0] CMD_WR_UPD     = 3'b011;
  localparam logic [2:0] CMD_PWR        = 3'b100;
  localparam logic [2:0] CMD_RST        = 3'b101;
  localparam logic [2:0] CMD_LDAC       = 3'b110;
  localparam logic [2:0] CMD_REF        = 3'b111;

  localparam logic [2:0] ADDR_A    = 3'b000;
  localparam logic [2:0] ADDR_B    = 3'b001;
  localparam logic [2:0] ADDR_GAIN = 3'b010;
  localparam logic [2:0] ADDR_ALL  = 3'b111;

  localparam int unsigned INIT_FRAMES = 5;

  typedef enum logic [1:0] {
    MODE_A     = 2'b00,
    MODE_B     = 2'b01,
    MODE_AB    = 2'b10,
    MODE_BCAST = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_PWRUP = 3'd0,
    ST_INIT  = 3'd1,
    ST_IDLE  = 3'd2,
    ST_LOAD  = 3'd3,
    ST_SHIFT = 3'd4,
    ST_GAP   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_HIGH = 2'd1,
    PH_LOW  = 2'd2,
    PH_TAIL = 2'd3
  } phase_e;

  function automatic logic [23:0] mk_frame(input logic [2:0] cmd, input logic [2:0] addr,
                                           input logic [15:0] data);
    return {2'b00, cmd, addr, data};
  endfunction

  function automatic logic [23:0] init_rom(input logic [2:0] idx, input logic gain_x2);
    case (idx)
      3'd0:    return mk_frame(CMD_RST, ADDR_A, 16'h0001);
      3'd1:    return mk_frame(CMD_PWR, ADDR_A, 16'h0003);
      3'd2:    return mk_frame(CMD_REF, ADDR_A, 16'h0001);
      3'd3:    return mk_frame(CMD_WR_IN, ADDR_GAIN, gain_x2 ? 16'h0000 : 16'h0003);
      default: return mk_frame(CMD_LDAC, ADDR_A, 16'h0003);
    endcase
  endfunction

  // Mode AB loads A without update first, then the B write updates both outputs together.
  function automatic logic [23:0] cmd_frame(input mode_e mode, input logic second,
                                            input logic [15:0] a, input logic [15:0] b);
    case (mode)
      MODE_A:  return mk_frame(CMD_WR_UPD, ADDR_A, a);
      MODE_B:  return mk_frame(CMD_WR_UPD, ADDR_B, b);
      MODE_AB: return second ? mk_frame(CMD_WR_UPD_ALL, ADDR_B, b) : mk_frame(CMD_WR_IN, ADDR_A, a);
      default: return mk_frame(CMD_WR_UPD, ADDR_ALL, a);
    endcase
  endfunction

endpackage

// File: rtl/dac8563_multi_ctrl_if.sv
// Valid/ready command port of the DAC8563 controller.
interface dac8563_multi_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_mode;
  logic [15:0] cmd_data_a;
  logic [15:0] cmd_data_b;

  modport master (output cmd_valid, output cmd_mode, output cmd_data_a, output cmd_data_b,
                  input cmd_ready);
  modport slave  (input cmd_valid, input cmd_mode, input cmd_data_a, input cmd_data_b,
                  output cmd_ready);
endinterface

// File: rtl/dac8563_multi_ctrl_spi_frame.sv
// Shifts one 24-bit frame out on SYNC/SCLK/MOSI; SCLK idles high, data changes on rising edges.
// done_o pulses in the cycle SYNC returns high.
module dac8563_multi_ctrl_spi_frame
  import dac8563_multi_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [23:0] frame_i,
  output logic        done_o,
  output logic        sync_o,
  output logic        sclk_o,
  output logic        mosi_o
);

  localparam int unsigned     DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0]   DIV_LAST = DW'(CLK_DIV - 1);

  phase_e         phase_q;
  logic [DW-1:0]  div_q;
  logic [4:0]     bit_q;
  logic [22:0]    sh_q;
  logic           sync_q, sclk_q, mosi_q, done_q;
  logic           div_tick;

  assign div_tick = (div_q == DIV_LAST);

  // Each SCLK half-period lasts CLK_DIV cycles; the tail keeps SYNC low one more half-period.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q <= PH_IDLE;
      div_q   <= '0;
      bit_q   <= 5'd0;
      sh_q    <= '0;
      sync_q  <= 1'b1;
      sclk_q  <= 1'b1;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (phase_q)
        PH_IDLE: if (start_i) begin
          sh_q    <= frame_i[22:0];
          mosi_q  <= frame_i[23];
          sync_q  <= 1'b0;
          sclk_q  <= 1'b1;
          div_q   <= '0;
          bit_q   <= 5'd0;
          phase_q <= PH_HIGH;
        end
        PH_HIGH: if (div_tick) begin
          div_q   <= '0;
          sclk_q  <= 1'b0;
          phase_q <= PH_LOW;
        end else div_q <= div_q + DW'(1);
        PH_LOW: if (div_tick) begin
          div_q  <= '0;
          sclk_q <= 1'b1;
          if (bit_q == 5'd23) phase_q <= PH_TAIL;
          else begin
            bit_q   <= bit_q + 5'd1;
            mosi_q  <= sh_q[22];
            sh_q    <= {sh_q[21:0], 1'b0};
            phase_q <= PH_HIGH;
          end
        end else div_q <= div_q + DW'(1);
        PH_TAIL: if (div_tick) begin
          div_q   <= '0;
          sync_q  <= 1'b1;
          mosi_q  <= 1'b0;
          done_q  <= 1'b1;
          phase_q <= PH_IDLE;
        end else div_q <= div_q + DW'(1);
        default: phase_q <= PH_IDLE;
      endcase
    end
  end

  assign done_o = done_q;
  assign sync_o = sync_q;
  assign sclk_o = sclk_q;
  assign mosi_o = mosi_q;

endmodule

// File: rtl/dac8563_multi_ctrl.sv
// DAC8563 controller: power-up wait, 5-frame init, then single/dual/broadcast writes
// taken one at a time from the valid/ready command port.
module dac8563_multi_ctrl
  import dac8563_multi_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned SYNC_GAP  = 4,
  parameter int unsigned PWRUP_CYC = 1000,
  parameter bit          GAIN_X2   = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  dac8563_multi_ctrl_if.slave  cmd_if,
  input  logic                 reinit_i,
  output logic                 init_done_o,
  output logic                 busy_o,
  output logic                 sync_o,
  output logic                 sclk_o,
  output logic                 mosi_o
);

  localparam int unsigned   PW       = $clog2(PWRUP_CYC + 1);
  localparam int unsigned   GW       = $clog2(SYNC_GAP + 1);
  localparam logic [PW-1:0] PWR_LAST = PW'(PWRUP_CYC - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(SYNC_GAP - 1);

  state_e         state_q;
  logic [PW-1:0]  pwr_q;
  logic [GW-1:0]  gap_q;
  logic [2:0]     idx_q;
  logic           in_init_q, second_q;
  mode_e          mode_q;
  logic [15:0]    a_q, b_q;
  logic           ready_q, busy_q, init_done_q;
  logic           spi_start, spi_done;
  logic [23:0]    spi_frame;

  // Sequencer: power-up wait, init ROM walk, command accept and frame/gap pacing.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_PWRUP;
      pwr_q       <= '0;
      gap_q       <= '0;
      idx_q       <= 3'd0;
      in_init_q   <= 1'b1;
      second_q    <= 1'b0;
      mode_q      <= MODE_A;
      a_q         <= 16'h0000;
      b_q         <= 16'h0000;
      ready_q     <= 1'b0;
      busy_q      <= 1'b1;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_PWRUP: if (pwr_q == PWR_LAST) begin
          pwr_q   <= '0;
          state_q <= ST_INIT;
        end else pwr_q <= pwr_q + PW'(1);
        ST_INIT, ST_LOAD: state_q <= ST_SHIFT;
        ST_SHIFT: if (spi_done) begin
          gap_q   <= '0;
          state_q <= ST_GAP;
        end
        ST_GAP: if (gap_q == GAP_LAST) begin
          gap_q <= '0;
          if (in_init_q) begin
            if (idx_q == 3'(INIT_FRAMES - 1)) begin
              in_init_q   <= 1'b0;
              init_done_q <= 1'b1;
              ready_q     <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= ST_IDLE;
            end else begin
              idx_q   <= idx_q + 3'd1;
              state_q <= ST_INIT;
            end
          end else if (mode_q == MODE_AB && !second_q) begin
            second_q <= 1'b1;
            state_q  <= ST_LOAD;
          end else begin
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end else gap_q <= gap_q + GW'(1);
        ST_IDLE: if (reinit_i) begin
          init_done_q <= 1'b0;
          ready_q     <= 1'b0;
          busy_q      <= 1'b1;
          in_init_q   <= 1'b1;
          idx_q       <= 3'd0;
          state_q     <= ST_INIT;
        end else if (cmd_if.cmd_valid && ready_q) begin
          mode_q   <= mode_e'(cmd_if.cmd_mode);
          a_q      <= cmd_if.cmd_data_a;
          b_q      <= cmd_if.cmd_data_b;
          second_q <= 1'b0;
          ready_q  <= 1'b0;
          busy_q   <= 1'b1;
          state_q  <= ST_LOAD;
        end
        default: state_q <= ST_PWRUP;
      endcase
    end
  end

  // Frame source for the shifter: init ROM entry or the latched command.
  always_comb begin
    spi_start = 1'b0;
    spi_frame = 24'h000000;
    if (state_q == ST_INIT) begin
      spi_start = 1'b1;
      spi_frame = init_rom(idx_q, GAIN_X2);
    end else if (state_q == ST_LOAD) begin
      spi_start = 1'b1;
      spi_frame = cmd_frame(mode_q, second_q, a_q, b_q);
    end else begin
      spi_start = 1'b0;
      spi_frame = 24'h000000;
    end
  end

  dac8563_multi_ctrl_spi_frame #(.CLK_DIV(CLK_DIV)) u_spi (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (spi_start),
    .frame_i (spi_frame),
    .done_o  (spi_done),
    .sync_o  (sync_o),
    .sclk_o  (sclk_o),
    .mosi_o  (mosi_o)
  );

  // A REINIT pulse in the same cycle must block acceptance.
  assign cmd_if.cmd_ready = ready_q & ~reinit_i;
  assign init_done_o      = init_done_q;
  assign busy_o           = busy_q;

endmodule
